mul_div_unit: RTL
=================

// Module: mul_div_unit
// PURPOSE
//  Iterative signed multiply/divide unit for the multi-cycle MIPS datapath (MULT, DIV).
//  Operands come from regs A and B; results feed the HI/LO control muxes ahead of the HI/LO registers.
//  Handshakes with control_unit through start strobes (MultCtrl/DivCtrl) and a done pulse.
//  Raises div_zero so control_unit can enter its exception sequence.
// PARAMETERS
//  WIDTH  32  operand width; product is 2*WIDTH; iteration count = WIDTH
// PORTS
//  clock       in   1      single clock, rising edge
//  reset       in   1      synchronous, active-high
//  start_mult  in   1      start signed multiply; sampled only in IDLE
//  start_div   in   1      start signed divide; sampled only in IDLE
//  op_a        in   WIDTH  multiplicand / dividend (reg A)
//  op_b        in   WIDTH  multiplier / divisor (reg B)
//  hi_out      out  WIDTH  MULT: product[63:32]; DIV: remainder
//  lo_out      out  WIDTH  MULT: product[31:0]; DIV: quotient
//  busy        out  1      high while iterating or fixing up
//  done        out  1      one-cycle pulse; hi_out/lo_out valid from this cycle
//  div_zero    out  1      one-cycle pulse; DIV started with op_b == 0
// BEHAVIOUR
//  Reset: every output = 0; FSM -> IDLE; internal accumulators cleared.
//  Clock and reset are fixed: one clock; reset is synchronous and active-high.
//  FSM states: IDLE, MULT, DIV, DIV_FIX, DONE.
//  Cycle 0 = cycle in which the start strobe is high in IDLE.
//  - IDLE: both strobes high -> multiply wins; divide is dropped.
//    - start_mult: latch operands; counter = WIDTH; -> MULT.
//    - start_div, op_b != 0: latch |op_a|, |op_b| and both signs; -> DIV.
//    - start_div, op_b == 0: div_zero = 1 in cycle 1 only; stay IDLE.
//      hi_out/lo_out unchanged; done never asserted.
//  - MULT: radix-2 Booth, one step per cycle, cycles 1..WIDTH (arithmetic right shift of {A,Q,q-1}).
//    - At the end of cycle WIDTH: load hi/lo, -> DONE. done = 1 in cycle WIDTH+1.
//  - DIV: restoring divide on magnitudes, one quotient bit per cycle, cycles 1..WIDTH; -> DIV_FIX.
//  - DIV_FIX (cycle WIDTH+1): apply signs, load hi/lo, -> DONE. done = 1 in cycle WIDTH+2.
//    - Quotient negated iff signs differ (truncation toward zero).
//    - Remainder takes the sign of the dividend.
//  - DONE: done = 1 for exactly one cycle; -> IDLE. Strobes are ignored in DONE.
//  busy = 1 in MULT, DIV, DIV_FIX; 0 in IDLE and DONE.
//  Strobes are ignored while not in IDLE; no queuing.
//  hi_out/lo_out hold the last result until the next done. They are never disturbed mid-operation.
//  Boundary cases:
//  - -2^31 / -1: quotient 0x80000000, remainder 0; no trap (MIPS DIV does not trap).
//  - -2^31 * -2^31: hi 0x40000000, lo 0x00000000.
//  - 0 dividend: quotient 0, remainder 0.
//  - Reset mid-operation: aborts on the next edge; outputs cleared to 0; no done pulse.
//  Magnitude registers are WIDTH+1 bits so that |-2^31| is representable.
// STRUCTURE
//  Shared package mul_div_pkg: state encoding (localparams IDLE..DONE) and MDU_WIDTH = 32.
//  Sub-module booth_mult: Booth datapath (A, Q, q-1, counter) with load/step/result ports.
//  Divider datapath and the FSM stay in mul_div_unit. Target is about 200-300 RTL lines total.
// TESTING
//  1. MULT 7 * -3 (0xFFFFFFFD) -> done in cycle 33; hi = 0xFFFFFFFF, lo = 0xFFFFFFEB.
//  2. MULT 0x80000000 * 0x80000000 -> hi = 0x40000000, lo = 0x00000000; busy high in cycles 1..32.
//  3. DIV -7 / 2 -> done in cycle 34; lo = 0xFFFFFFFD (-3), hi = 0xFFFFFFFF (-1).
//     DIV 0x80000000 / 0xFFFFFFFF -> lo = 0x80000000, hi = 0.
//  4. DIV 5 / 0 -> div_zero high in cycle 1 only; done never asserted; hi/lo keep prior values; busy stays 0.
//  5. start_mult and start_div together (6, 3) -> product result (lo = 18).
//     A start_div pulsed in cycle 10 is ignored.
//  6. Reset in cycle 15 of a DIV -> all outputs 0 at the next edge; no done.
//     A new MULT 2 * 3 then gives lo = 6.

Source files
------------

// File: rtl/mul_div_pkg.sv
// rtl/mul_div_pkg.sv - shared width and FSM state encoding for the multiply/divide unit
//
// Purpose: constants and the state type used by mul_div_unit and booth_mult.
// Ports:   none (package).
package mul_div_pkg;

   localparam int MDU_WIDTH = 32;

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      MULT    = 3'd1,
      DIV     = 3'd2,
      DIV_FIX = 3'd3,
      DONE    = 3'd4
   } mduState_t;

endpackage

// File: rtl/booth_mult.sv
// rtl/booth_mult.sv - radix-2 Booth multiplier datapath, one step per clock
//
// Purpose: holds the Booth accumulator A, multiplier Q, the q-1 bit and the step
//          counter; the controlling FSM decides when to load and when to step.
// Ports:
//   clock, reset      rising-edge clock, synchronous active-high reset
//   load              latch multiplicand/multiplier, counter = WIDTH
//   step              perform one Booth add/sub + arithmetic right shift
//   multiplicand      signed operand (M)
//   multiplier        signed operand (Q)
//   last              current step is the final one (counter == 1)
//   product           2*WIDTH product as it will be after the current step
import mul_div_pkg::*;

module booth_mult #(
   parameter int WIDTH = MDU_WIDTH
) (
   input  logic               clock,
   input  logic               reset,
   input  logic               load,
   input  logic               step,
   input  logic [WIDTH-1:0]   multiplicand,
   input  logic [WIDTH-1:0]   multiplier,
   output logic               last,
   output logic [2*WIDTH-1:0] product
);

   localparam int CW = $clog2(WIDTH + 1);

   // A and M carry one extra sign bit so that subtracting M = -2^(WIDTH-1)
   // cannot overflow the accumulator.
   logic [WIDTH:0]   accA;
   logic [WIDTH:0]   regM;
   logic [WIDTH-1:0] regQ;
   logic             qm1;
   logic [CW-1:0]    count;

   logic [WIDTH:0]   sum;
   logic [WIDTH:0]   nextA;
   logic [WIDTH-1:0] nextQ;

   always_comb begin
      sum = accA;
      case ({regQ[0], qm1})
         2'b01:   sum = accA + regM;
         2'b10:   sum = accA - regM;
         default: sum = accA;
      endcase
      nextA = {sum[WIDTH], sum[WIDTH:1]};
      nextQ = {sum[0], regQ[WIDTH-1:1]};
   end

   // Exposing the post-step value lets the FSM load HI/LO in the same cycle
   // as the final step.
   assign product = {nextA[WIDTH-1:0], nextQ};
   assign last    = (count == CW'(1));

   always_ff @(posedge clock) begin
      if (reset) begin
         accA  <= '0;
         regM  <= '0;
         regQ  <= '0;
         qm1   <= 1'b0;
         count <= '0;
      end else if (load) begin
         accA  <= '0;
         regM  <= {multiplicand[WIDTH-1], multiplicand};
         regQ  <= multiplier;
         qm1   <= 1'b0;
         count <= CW'(WIDTH);
      end else if (step && (count != '0)) begin
         accA  <= nextA;
         regQ  <= nextQ;
         qm1   <= regQ[0];
         count <= count - CW'(1);
      end
   end

endmodule

// File: rtl/mul_div_unit.sv
// rtl/mul_div_unit.sv - iterative signed MULT/DIV unit feeding the HI/LO muxes
//
// Purpose: signed Booth multiply (WIDTH+1 cycles to done) and signed restoring
//          divide (WIDTH+2 cycles to done) with a divide-by-zero pulse.
// Ports:
//   clock, reset   rising-edge clock, synchronous active-high reset
//   start_mult     start signed multiply (IDLE only, wins over start_div)
//   start_div      start signed divide (IDLE only)
//   op_a, op_b     multiplicand/dividend, multiplier/divisor
//   hi_out         MULT: product high half; DIV: remainder
//   lo_out         MULT: product low half;  DIV: quotient
//   busy           high in MULT, DIV, DIV_FIX
//   done           one-cycle pulse, hi_out/lo_out valid from this cycle
//   div_zero       one-cycle pulse when a divide starts with op_b == 0
import mul_div_pkg::*;

module mul_div_unit #(
   parameter int WIDTH = MDU_WIDTH
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             start_mult,
   input  logic             start_div,
   input  logic [WIDTH-1:0] op_a,
   input  logic [WIDTH-1:0] op_b,
   output logic [WIDTH-1:0] hi_out,
   output logic [WIDTH-1:0] lo_out,
   output logic             busy,
   output logic             done,
   output logic             div_zero
);

   localparam int CW = $clog2(WIDTH + 1);

   mduState_t        state;
   logic [CW-1:0]    divCount;
   logic [WIDTH:0]   remReg;
   logic [WIDTH:0]   divisorReg;
   logic [WIDTH-1:0] quoReg;
   logic             signA;
   logic             signB;

   logic               boothLoad;
   logic               boothStep;
   logic               boothLast;
   logic [2*WIDTH-1:0] boothProduct;

   assign boothLoad = (state == IDLE) && start_mult;
   assign boothStep = (state == MULT);

   booth_mult #(.WIDTH(WIDTH)) uBooth (
      .clock        (clock),
      .reset        (reset),
      .load         (boothLoad),
      .step         (boothStep),
      .multiplicand (op_a),
      .multiplier   (op_b),
      .last         (boothLast),
      .product      (boothProduct)
   );

   // Unsigned magnitudes; |-2^(WIDTH-1)| still fits as an unsigned WIDTH-bit value.
   logic [WIDTH-1:0] absA;
   logic [WIDTH-1:0] absB;
   assign absA = op_a[WIDTH-1] ? (~op_a + WIDTH'(1)) : op_a;
   assign absB = op_b[WIDTH-1] ? (~op_b + WIDTH'(1)) : op_b;

   // Restoring step: shift the next dividend bit into the partial remainder and
   // keep the difference only when it did not borrow.
   logic [WIDTH+1:0] shifted;
   logic [WIDTH+1:0] diff;
   logic             borrow;
   assign shifted = {remReg, quoReg[WIDTH-1]};
   assign diff    = shifted - {1'b0, divisorReg};
   assign borrow  = diff[WIDTH+1];

   // Quotient truncates toward zero; remainder follows the dividend's sign.
   logic [WIDTH-1:0] quoFixed;
   logic [WIDTH-1:0] remFixed;
   assign quoFixed = (signA ^ signB) ? (~quoReg + WIDTH'(1)) : quoReg;
   assign remFixed = signA ? (~remReg[WIDTH-1:0] + WIDTH'(1)) : remReg[WIDTH-1:0];

   always_ff @(posedge clock) begin
      if (reset) begin
         state      <= IDLE;
         divCount   <= '0;
         remReg     <= '0;
         divisorReg <= '0;
         quoReg     <= '0;
         signA      <= 1'b0;
         signB      <= 1'b0;
         hi_out     <= '0;
         lo_out     <= '0;
         busy       <= 1'b0;
         done       <= 1'b0;
         div_zero   <= 1'b0;
      end else begin
         done     <= 1'b0;
         div_zero <= 1'b0;
         case (state)
            IDLE: begin
               if (start_mult) begin
                  busy  <= 1'b1;
                  state <= MULT;
               end else if (start_div) begin
                  if (op_b == '0) begin
                     div_zero <= 1'b1;
                  end else begin
                     remReg     <= '0;
                     quoReg     <= absA;
                     divisorReg <= {1'b0, absB};
                     signA      <= op_a[WIDTH-1];
                     signB      <= op_b[WIDTH-1];
                     divCount   <= CW'(WIDTH);
                     busy       <= 1'b1;
                     state      <= DIV;
                  end
               end
            end
            MULT: begin
               if (boothLast) begin
                  hi_out <= boothProduct[2*WIDTH-1:WIDTH];
                  lo_out <= boothProduct[WIDTH-1:0];
                  busy   <= 1'b0;
                  done   <= 1'b1;
                  state  <= DONE;
               end
            end
            DIV: begin
               remReg   <= borrow ? shifted[WIDTH:0] : diff[WIDTH:0];
               quoReg   <= {quoReg[WIDTH-2:0], ~borrow};
               divCount <= divCount - CW'(1);
               if (divCount == CW'(1)) begin
                  state <= DIV_FIX;
               end
            end
            DIV_FIX: begin
               hi_out <= remFixed;
               lo_out <= quoFixed;
               busy   <= 1'b0;
               done   <= 1'b1;
               state  <= DONE;
            end
            DONE: begin
               state <= IDLE;
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule
